// File: rtl/pipeline_sched_pkg.sv
// Shared constants and the round-robin pick function used by the scheduler
// (and usable by any reference model that wants the same arbitration rule).
package pipeline_sched_pkg;

  localparam int DefNumReq         = 4;
  localparam int DefWidth          = 15;
  localparam int DefDepth          = 2;
  localparam int DefMaxOutstanding = 2;

  localparam int MaxReq = 32;
  localparam int PickW  = 5;

  typedef struct packed {
    logic             found;
    logic [PickW-1:0] index;
  } pick_t;

  // Scans upward from ptr with wrap-around; index is 0 when nothing is found.
  function automatic pick_t rr_pick(input logic [MaxReq-1:0] eligible,
                                    input int unsigned       num_req,
                                    input int unsigned       ptr);
    pick_t       res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      if (k < num_req && !res.found) begin
        idx = ptr + k;
        if (idx >= num_req) idx = idx - num_req;
        if (eligible[idx]) begin
          res.found = 1'b1;
          res.index = idx[PickW-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pipeline.sv
// Fixed-latency data pipeline without reset; Depth=0 is a plain wire.
module pipeline #(
  parameter int Width = 8,
  parameter int Depth = 1
) (
  input  logic             clk,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  generate
    if (Depth == 0) begin : g_comb
      assign q = d;
    end else begin : g_regs
      logic [Width-1:0] stage [Depth];

      always_ff @(posedge clk) begin
        stage[0] <= d;
        for (int s = 1; s < Depth; s++) stage[s] <= stage[s-1];
      end

      assign q = stage[Depth-1];
    end
  endgenerate

endmodule

// File: rtl/pipeline_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency pipeline among NumReq
// requesters, with a resettable valid/ID tag line and per-requester credits.
module pipeline_rr_sched
  import pipeline_sched_pkg::*;
#(
  parameter int NumReq         = DefNumReq,
  parameter int Width          = DefWidth,
  parameter int Depth          = DefDepth,
  parameter int MaxOutstanding = DefMaxOutstanding,
  localparam int IdW  = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NumReq-1:0]       req_valid,
  input  logic [NumReq*Width-1:0] req_data,
  output logic [NumReq-1:0]       req_ready,
  output logic [NumReq-1:0]       rsp_valid,
  output logic [IdW-1:0]          rsp_id,
  output logic [Width-1:0]        rsp_data,
  output logic                    busy
);

  logic [IdW-1:0]    ptr;
  logic [CntW-1:0]   out_cnt [NumReq];
  logic [NumReq-1:0] eligible;
  logic [NumReq-1:0] returning;
  logic [NumReq-1:0] grant;
  logic              grant_valid;
  logic [IdW-1:0]    grant_id;
  pick_t             pick;
  logic [Width-1:0]  pipe_d;
  logic [Width-1:0]  pipe_q;
  logic              tag_valid_out;
  logic [IdW-1:0]    tag_id_out;
  logic              ret_valid;
  logic [IdW-1:0]    ret_id;
  logic              tag_any;
  logic              cnt_any;

  // A returning response frees its credit in the same cycle it leaves.
  always_comb begin
    returning = '0;
    eligible  = '0;
    for (int i = 0; i < NumReq; i++) begin
      returning[i] = ret_valid && (ret_id == IdW'(i));
      eligible[i]  = req_valid[i] &&
                     ((out_cnt[i] < CntW'(MaxOutstanding)) || returning[i]);
    end
  end

  always_comb begin
    pick        = rr_pick(MaxReq'(eligible), NumReq, 32'(ptr));
    grant_valid = pick.found;
    grant_id    = pick.index[IdW-1:0];
    grant       = '0;
    pipe_d      = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant_valid && grant_id == IdW'(i)) begin
        grant[i] = 1'b1;
        pipe_d   = req_data[i*Width +: Width];
      end
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_id == IdW'(NumReq - 1)) ? '0 : grant_id + IdW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumReq; i++) out_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (grant[i] && !rsp_valid[i]) begin
          out_cnt[i] <= out_cnt[i] + CntW'(1);
        end else if (!grant[i] && rsp_valid[i]) begin
          out_cnt[i] <= out_cnt[i] - CntW'(1);
        end
      end
    end
  end

  pipeline #(
    .Width(Width),
    .Depth(Depth)
  ) u_data_pipe (
    .clk(clk),
    .d  (pipe_d),
    .q  (pipe_q)
  );

  // With Depth=0 the return path is the grant itself; it is kept out of the
  // eligibility logic to avoid a combinational loop (credits never move).
  generate
    if (Depth == 0) begin : g_tag_comb
      assign tag_valid_out = grant_valid;
      assign tag_id_out    = grant_id;
      assign ret_valid     = 1'b0;
      assign ret_id        = '0;
      assign tag_any       = 1'b0;
    end else begin : g_tag_regs
      logic [Depth-1:0] tag_v;
      logic [IdW-1:0]   tag_i [Depth];

      always_ff @(posedge clk) begin
        if (rst) begin
          tag_v <= '0;
          for (int s = 0; s < Depth; s++) tag_i[s] <= '0;
        end else begin
          tag_v[0] <= grant_valid;
          tag_i[0] <= grant_id;
          for (int s = 1; s < Depth; s++) begin
            tag_v[s] <= tag_v[s-1];
            tag_i[s] <= tag_i[s-1];
          end
        end
      end

      assign tag_valid_out = tag_v[Depth-1];
      assign tag_id_out    = tag_i[Depth-1];
      assign ret_valid     = tag_v[Depth-1];
      assign ret_id        = tag_i[Depth-1];
      assign tag_any       = |tag_v;
    end
  endgenerate

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NumReq; i++) begin
      rsp_valid[i] = tag_valid_out && (tag_id_out == IdW'(i));
    end
    rsp_id   = tag_valid_out ? tag_id_out : '0;
    rsp_data = tag_valid_out ? pipe_q : '0;
  end

  always_comb begin
    cnt_any = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      cnt_any = cnt_any | (out_cnt[i] != '0);
    end
    busy = cnt_any | tag_any;
  end

endmodule

// File: tb/tb_pipeline_rr_sched.sv
// Directed bench for pipeline_rr_sched: four instances cover Depth 2, 8, 4
// and 0; each task drives vectors at negedge and compares just after.
module tb_pipeline_rr_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic [3:0]  rv_a, rr_a, rs_a, rv_b, rr_b, rs_b;
  logic [3:0]  rv_c, rr_c, rs_c, rv_z, rr_z, rs_z;
  logic [59:0] rd_a, rd_b, rd_c, rd_z;
  logic [1:0]  ri_a, ri_b, ri_c, ri_z;
  logic [14:0] rdat_a, rdat_b, rdat_c, rdat_z;
  logic        busy_a, busy_b, busy_c, busy_z;

  pipeline_rr_sched #(.NumReq(4), .Width(15), .Depth(2), .MaxOutstanding(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(rv_a), .req_data(rd_a), .req_ready(rr_a),
    .rsp_valid(rs_a), .rsp_id(ri_a), .rsp_data(rdat_a), .busy(busy_a));

  pipeline_rr_sched #(.NumReq(4), .Width(15), .Depth(8), .MaxOutstanding(2)) dut_b (
    .clk(clk), .rst(rst), .req_valid(rv_b), .req_data(rd_b), .req_ready(rr_b),
    .rsp_valid(rs_b), .rsp_id(ri_b), .rsp_data(rdat_b), .busy(busy_b));

  pipeline_rr_sched #(.NumReq(4), .Width(15), .Depth(4), .MaxOutstanding(2)) dut_c (
    .clk(clk), .rst(rst), .req_valid(rv_c), .req_data(rd_c), .req_ready(rr_c),
    .rsp_valid(rs_c), .rsp_id(ri_c), .rsp_data(rdat_c), .busy(busy_c));

  pipeline_rr_sched #(.NumReq(4), .Width(15), .Depth(0), .MaxOutstanding(2)) dut_z (
    .clk(clk), .rst(rst), .req_valid(rv_z), .req_data(rd_z), .req_ready(rr_z),
    .rsp_valid(rs_z), .rsp_id(ri_z), .rsp_data(rdat_z), .busy(busy_z));

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rv_a = '0; rv_b = '0; rv_c = '0; rv_z = '0;
    rd_a = '0; rd_b = '0; rd_c = '0; rd_z = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rv_a = '0;
      #1;
      checks++;
      if (rs_a !== 4'b0000) begin failures++; $display("[TB] FAIL reset_rsp_valid c=%0d got=%b exp=0000", c, rs_a); end
      checks++;
      if (rdat_a !== 15'd0) begin failures++; $display("[TB] FAIL reset_rsp_data c=%0d got=%0d exp=0", c, rdat_a); end
      checks++;
      if (ri_a !== 2'd0) begin failures++; $display("[TB] FAIL reset_rsp_id c=%0d got=%0d exp=0", c, ri_a); end
      checks++;
      if (busy_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy c=%0d got=%b exp=0", c, busy_a); end
      checks++;
      if (rr_a !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ready c=%0d got=%b exp=0000", c, rr_a); end
    end
    @(negedge clk);
    rv_a = 4'b1111;
    #1;
    checks++;
    if (rr_a !== 4'b0001) begin failures++; $display("[TB] FAIL reset_ptr_zero got=%b exp=0001", rr_a); end
    @(negedge clk);
    rv_a = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    int         r;
    do_reset();
    rd_a = {15'd3, 15'd2, 15'd1, 15'd0};
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      rv_a = 4'b1111;
      #1;
      exp_g = 4'b0001 << (c % 4);
      checks++;
      if (rr_a !== exp_g) begin failures++; $display("[TB] FAIL rr_grant c=%0d got=%b exp=%b", c, rr_a, exp_g); end
      if (c >= 2) begin
        r = (c - 2) % 4;
        exp_g = 4'b0001 << r;
        checks++;
        if (rs_a !== exp_g) begin failures++; $display("[TB] FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, rs_a, exp_g); end
        checks++;
        if (ri_a !== 2'(r)) begin failures++; $display("[TB] FAIL rr_rsp_id c=%0d got=%0d exp=%0d", c, ri_a, r); end
        checks++;
        if (rdat_a !== 15'(r)) begin failures++; $display("[TB] FAIL rr_rsp_data c=%0d got=%0d exp=%0d", c, rdat_a, r); end
        checks++;
        if (busy_a !== 1'b1) begin failures++; $display("[TB] FAIL rr_busy c=%0d got=%b exp=1", c, busy_a); end
      end else begin
        checks++;
        if (rs_a !== 4'b0000) begin failures++; $display("[TB] FAIL rr_rsp_early c=%0d got=%b exp=0000", c, rs_a); end
      end
    end
    @(negedge clk);
    rv_a = '0;
  endtask

  task automatic test_credit();
    logic [3:0] exp_g;
    logic       exp_rsp;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      rv_b = 4'b0010;
      rd_b = '0;
      rd_b[15 +: 15] = 15'(c + 100);
      #1;
      exp_g = ((c % 8) < 2) ? 4'b0010 : 4'b0000;
      exp_rsp = (c >= 8) && ((c % 8) < 2);
      checks++;
      if (rr_b !== exp_g) begin failures++; $display("[TB] FAIL credit_grant c=%0d got=%b exp=%b", c, rr_b, exp_g); end
      checks++;
      if (rs_b !== (exp_rsp ? 4'b0010 : 4'b0000)) begin failures++; $display("[TB] FAIL credit_rsp_valid c=%0d got=%b exp_rsp=%b", c, rs_b, exp_rsp); end
      if (exp_rsp) begin
        checks++;
        if (rdat_b !== 15'(c - 8 + 100)) begin failures++; $display("[TB] FAIL credit_rsp_data c=%0d got=%0d exp=%0d", c, rdat_b, c - 8 + 100); end
        checks++;
        if (ri_b !== 2'd1) begin failures++; $display("[TB] FAIL credit_rsp_id c=%0d got=%0d exp=1", c, ri_b); end
      end
      checks++;
      if (busy_b !== (c != 0)) begin failures++; $display("[TB] FAIL credit_busy c=%0d got=%b exp=%b", c, busy_b, (c != 0)); end
    end
    @(negedge clk);
    rv_b = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    rd_a = {15'd33, 15'd22, 15'd11, 15'd0};
    @(negedge clk);
    rv_a = 4'b0100;
    #1;
    checks++;
    if (rr_a !== 4'b0100) begin failures++; $display("[TB] FAIL wrap_first got=%b exp=0100", rr_a); end
    @(negedge clk);
    rv_a = 4'b0100;
    #1;
    checks++;
    if (rr_a !== 4'b0100) begin failures++; $display("[TB] FAIL wrap_around got=%b exp=0100", rr_a); end
    @(negedge clk);
    rv_a = 4'b1111;
    #1;
    checks++;
    if (rr_a !== 4'b1000) begin failures++; $display("[TB] FAIL wrap_ptr_next got=%b exp=1000", rr_a); end
    checks++;
    if (rs_a !== 4'b0100 || rdat_a !== 15'd22) begin failures++; $display("[TB] FAIL wrap_rsp got=%b/%0d exp=0100/22", rs_a, rdat_a); end
    @(negedge clk);
    rv_a = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rv_c = 4'b0001;
      rd_c = '0;
      rd_c[14:0] = 15'(5 + c);
      #1;
      checks++;
      if (rr_c !== 4'b0001) begin failures++; $display("[TB] FAIL mid_grant c=%0d got=%b exp=0001", c, rr_c); end
    end
    @(negedge clk);
    rv_c = '0;
    rst = 1'b1;
    for (int c = 3; c < 9; c++) begin
      @(negedge clk);
      rst = 1'b0;
      rv_c = '0;
      #1;
      checks++;
      if (rs_c !== 4'b0000) begin failures++; $display("[TB] FAIL mid_dropped c=%0d got=%b exp=0000", c, rs_c); end
      checks++;
      if (busy_c !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy c=%0d got=%b exp=0", c, busy_c); end
    end
    @(negedge clk);
    rv_c = 4'b0001;
    rd_c[14:0] = 15'd9;
    #1;
    checks++;
    if (rr_c !== 4'b0001) begin failures++; $display("[TB] FAIL mid_new_grant got=%b exp=0001", rr_c); end
    for (int c = 10; c < 14; c++) begin
      @(negedge clk);
      rv_c = '0;
      #1;
      if (c < 13) begin
        checks++;
        if (rs_c !== 4'b0000 || busy_c !== 1'b1) begin failures++; $display("[TB] FAIL mid_wait c=%0d got=%b busy=%b exp=0000 busy=1", c, rs_c, busy_c); end
      end else begin
        checks++;
        if (rs_c !== 4'b0001 || rdat_c !== 15'd9 || ri_c !== 2'd0) begin failures++; $display("[TB] FAIL mid_new_rsp got=%b/%0d/%0d exp=0001/9/0", rs_c, rdat_c, ri_c); end
      end
    end
  endtask

  logic [3:0] z_valid [5] = '{4'b1111, 4'b1111, 4'b0100, 4'b0011, 4'b0000};
  logic [3:0] z_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0000};
  int         z_idx   [5] = '{0, 1, 2, 0, 0};

  task automatic test_depth0();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rv_z = z_valid[c];
      for (int i = 0; i < 4; i++) rd_z[i*15 +: 15] = 15'(16 * c + i + 1);
      #1;
      checks++;
      if (rr_z !== z_grant[c]) begin failures++; $display("[TB] FAIL d0_grant c=%0d got=%b exp=%b", c, rr_z, z_grant[c]); end
      checks++;
      if (rs_z !== z_grant[c]) begin failures++; $display("[TB] FAIL d0_rsp_valid c=%0d got=%b exp=%b", c, rs_z, z_grant[c]); end
      checks++;
      if (busy_z !== 1'b0) begin failures++; $display("[TB] FAIL d0_busy c=%0d got=%b exp=0", c, busy_z); end
      if (z_grant[c] != 4'b0000) begin
        checks++;
        if (rdat_z !== 15'(16 * c + z_idx[c] + 1) || ri_z !== 2'(z_idx[c])) begin
          failures++;
          $display("[TB] FAIL d0_rsp c=%0d got=%0d/%0d exp=%0d/%0d", c, rdat_z, ri_z, 16 * c + z_idx[c] + 1, z_idx[c]);
        end
      end else begin
        checks++;
        if (rdat_z !== 15'd0) begin failures++; $display("[TB] FAIL d0_idle_data c=%0d got=%0d exp=0", c, rdat_z); end
      end
    end
    @(negedge clk);
    rv_z = '0;
  endtask

  initial begin
    rv_a = '0; rv_b = '0; rv_c = '0; rv_z = '0;
    rd_a = '0; rd_b = '0; rd_c = '0; rd_z = '0;
    test_reset();
    test_round_robin();
    test_credit();
    test_wrap();
    test_reset_mid();
    test_depth0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_rr_sched.md
# pipeline_rr_sched

Round-robin scheduler sharing one fixed-latency `pipeline` datapath among NumReq requesters. Each cycle it grants at most one eligible requester, pushes that requester's word into the pipeline with a parallel valid/ID tag line, and returns the result Depth cycles later on that requester's response strobe. Per-requester outstanding-credit limits keep any one requester from filling the pipeline. It sits between client blocks and the shared pipeline.

## Interface
- NumReq, 4: number of requesters, ≥1.
- Width, 15: data width.
- Depth, 2: pipeline latency in cycles, ≥0.
- MaxOutstanding, 2: in-flight limit per requester, ≥1.
- IdW (localparam): max(1, $clog2(NumReq)).
- CntW (localparam): $clog2(MaxOutstanding+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NumReq  request pending, one bit per requester.
- req_data  in  NumReq*Width  requester i's word is at bits [i*Width +: Width].
- req_ready  out  NumReq  one-hot grant, combinational. A transfer occurs when valid&ready.
- rsp_valid  out  NumReq  one-hot result strobe.
- rsp_id  out  IdW  requester index of the current result.
- rsp_data  out  Width  result word. Forced to '0 when no rsp_valid bit is set.
- busy  out  1  any tag in flight, or any outstanding counter nonzero.

## Operation
- eligible[i] = req_valid[i] && (out_cnt[i] < MaxOutstanding || the response for i is returning this cycle).
- Grant selection: first eligible index found scanning upward from ptr, with wrap-around. req_ready has at most one bit set, and that bit is set only if eligible.
- Pointer update:
  - On a grant to index g: ptr <= (g+1) mod NumReq.
  - With no grant: ptr holds.
- Datapath:
  - The granted word feeds pipeline input d. With no grant, d = '0.
  - Tag line: a Depth-stage register chain of {valid, id}, reset to 0. It advances every cycle with no stall.
- Response: when the tag-line output is valid, assert rsp_valid[id]. Set rsp_id = id and rsp_data = pipeline q.
- Outstanding counters:
  - Increment on grant; decrement on response.
  - Grant and response for the same requester in the same cycle: counter unchanged.
  - Counters never exceed MaxOutstanding and never underflow.
- Depth=0:
  - Pipeline and tag line are combinational.
  - The response appears in the same cycle as the grant; counters stay 0.
- No backpressure on responses: the consumer must accept every rsp_valid.

## Timing
- Reset values: ptr=0, all out_cnt=0, tag valids=0. Therefore req_ready is driven by the eligibility logic, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
- Latency: a grant in cycle N produces the response in cycle N+Depth.
- Throughput: one grant per cycle total.
- A single requester alone sustains MaxOutstanding grants per Depth cycles when Depth > MaxOutstanding. Otherwise it sustains one grant per cycle.
- Reset mid-operation:
  - All in-flight tags are dropped; no response is ever produced for them.
  - Counters return to 0.
  - Residual pipeline data is masked by the rsp_data rule.
- A req_valid deassertion without a grant is legal. The scheduler keeps no memory of it.

## Structure
- Package pipeline_sched_pkg holds:
  - default parameter constants;
  - function rr_pick(eligible, ptr) returning {found, index}, shared with the bench's reference model.
- Sub-module: the existing `pipeline` (Width, Depth), instantiated as u_data_pipe for the data path.
- The tag line is inline, because it needs reset and `pipeline` has none.
- All state lives in always_ff blocks; grant logic is always_comb.

## Test plan
- Reset, then all req_valid=0 for 20 cycles -> rsp_valid=0, rsp_data=0, busy=0, ptr stays 0.
- NumReq=4, Depth=2, all four requesters valid continuously, data = requester index -> grants in order 0,1,2,3,0,… every cycle. Each result appears 2 cycles after its grant with the matching rsp_id and data.
- Depth=8, MaxOutstanding=2, only requester 1 valid -> grants in cycles 0 and 1, none in cycles 2–7, then resumes in cycle 8 as the first response returns (same-cycle credit reuse). out_cnt[1] never exceeds 2.
- Requester 2 is the sole valid requester while ptr=3 -> grant wraps to 2. Next ptr=3.
- Reset asserted with 2 items in flight (Depth=4) -> no rsp_valid for the dropped items after reset releases. Counters are 0; a new grant responds 4 cycles later.
- Depth=0 -> rsp_valid[g] and rsp_data = req_data[g] in the same cycle as the grant; busy stays 0.
